// File: rtl/string_matcher_if.sv
// Character stream and match-status bundle for string_matcher.
// The master side feeds characters; the slave side (the matcher) reports results.
interface string_matcher_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       hout;
    logic       pl;
    logic [7:0] match_cnt;
    logic [1:0] state_dbg;

    modport master (
        output char_in,
        output char_valid,
        input  hout,
        input  pl,
        input  match_cnt,
        input  state_dbg
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output hout,
        output pl,
        output match_cnt,
        output state_dbg
    );
endinterface

// File: rtl/string_matcher.sv
// Four-character KMP stream matcher with word-boundary reset and saturating match counter.
// Define STRING_MATCHER_CASE_FOLD_EN for case-insensitive pattern comparison.
module string_matcher #(
    parameter logic [7:0] PAT0  = 8'h61,
    parameter logic [7:0] PAT1  = 8'h62,
    parameter logic [7:0] PAT2  = 8'h63,
    parameter logic [7:0] PAT3  = 8'h64,
    parameter logic [7:0] DELIM = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    string_matcher_if.slave  bus
);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    if (DELIM == PAT0 || DELIM == PAT1 || DELIM == PAT2 || DELIM == PAT3) begin : g_delim_clash
        $error("string_matcher: DELIM must differ from every pattern character");
    end

`ifdef STRING_MATCHER_CASE_FOLD_EN
    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
    endfunction

    localparam logic [31:0] PATV = {fold(PAT3), fold(PAT2), fold(PAT1), fold(PAT0)};

    logic [7:0] char_cmp;
    assign char_cmp = fold(bus.char_in);
`else
    localparam logic [31:0] PATV = {PAT3, PAT2, PAT1, PAT0};

    logic [7:0] char_cmp;
    assign char_cmp = bus.char_in;
`endif

    function automatic logic [7:0] pat_at(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = PATV[7:0];
            2'd1:    c = PATV[15:8];
            2'd2:    c = PATV[23:16];
            default: c = PATV[31:24];
        endcase
        return c;
    endfunction

    // Bit {d,L}: the first L pattern chars equal the last L of the first d (a border of the depth-d prefix).
    function automatic logic [15:0] calc_borders();
        logic [15:0] b;
        logic        ok;
        b = '0;
        for (int d = 0; d < 4; d++) begin
            for (int l = 0; l <= d; l++) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (pat_at(2'(i)) != pat_at(2'(d - l + i))) ok = 1'b0;
                end
                b[4'(d * 4 + l)] = ok;
            end
        end
        return b;
    endfunction

    // Depth to resume at after a full match: longest proper border of the whole pattern.
    function automatic logic [1:0] calc_full_fallback();
        logic [1:0] fb;
        logic       ok;
        fb = 2'd0;
        for (int j = 1; j < 4; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_at(2'(i)) != pat_at(2'(4 - j + i))) ok = 1'b0;
            end
            if (ok) fb = 2'(j);
        end
        return fb;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    localparam logic [15:0] BORDERS = calc_borders();
    localparam logic [1:0]  FULL_FB = calc_full_fallback();

    state_t     state_p1;
    state_t     state_nxt;
    logic       hout_p1;
    logic       pl_p1;
    logic [7:0] match_cnt_p1;
    logic       hout_nxt;
    logic       pl_nxt;
    logic       hit;

    always_comb begin
        state_nxt = state_p1;
        hout_nxt  = 1'b0;
        pl_nxt    = 1'b0;
        hit       = 1'b0;
        if (bus.char_valid) begin
            if (bus.char_in == DELIM) begin
                state_nxt = S0;
                pl_nxt    = 1'b1;
            end else if (char_cmp == pat_at(state_p1)) begin
                if (state_p1 == S3) begin
                    hout_nxt  = 1'b1;
                    hit       = 1'b1;
                    state_nxt = state_t'(FULL_FB);
                end else begin
                    state_nxt = state_t'(state_p1 + 2'd1);
                end
            end else begin
                // Largest j whose (j-1)-char border of the matched prefix extends with char_in.
                state_nxt = S0;
                for (int j = 1; j < 4; j++) begin
                    if (2'(j) <= state_p1 &&
                        BORDERS[{state_p1, 2'(j - 1)}] &&
                        char_cmp == pat_at(2'(j - 1))) begin
                        state_nxt = state_t'(2'(j));
                    end
                end
            end
        end
    end

    // Stage p1: registered state, pulses and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1     <= S0;
            hout_p1      <= 1'b0;
            pl_p1        <= 1'b0;
            match_cnt_p1 <= 8'd0;
        end else begin
            state_p1 <= state_nxt;
            hout_p1  <= hout_nxt;
            pl_p1    <= pl_nxt;
            if (hit) match_cnt_p1 <= sat_inc(match_cnt_p1);
        end
    end

    assign bus.hout      = hout_p1;
    assign bus.pl        = pl_p1;
    assign bus.match_cnt = match_cnt_p1;
    assign bus.state_dbg = state_p1;

endmodule

// File: doc/string_matcher.md
STRING_MATCHER -- requirements
Module: string_matcher

Interface
REQ-001 Parameter PAT0, default 8'h61 ('a'): first pattern character.
REQ-002 Parameter PAT1, default 8'h62 ('b'): second pattern character.
REQ-003 Parameter PAT2, default 8'h63 ('c'): third pattern character.
REQ-004 Parameter PAT3, default 8'h64 ('d'): fourth (final) pattern character.
REQ-005 Parameter DELIM, default 8'h20 (space): word-boundary character; SHALL NOT equal any PATn (elaboration-time check).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 char_in  input  8  incoming character, sampled only when char_valid=1.
REQ-009 char_valid  input  1  qualifies char_in for one cycle; each high cycle is one accepted character.
REQ-010 hout  output  1  registered one-cycle pulse: final pattern character accepted.
REQ-011 pl  output  1  registered one-cycle pulse: DELIM accepted (word boundary).
REQ-012 match_cnt  output  8  number of full matches since reset, saturating.
REQ-013 state_dbg  output  2  current match depth (0..3), for debug.

Function
REQ-014 FSM states S0..S3 = number of consecutive pattern characters currently matched (prefix length).
REQ-015 char_valid=0: state, match_cnt held; hout=0, pl=0 next cycle.
REQ-016 Accepted char == DELIM: next state S0, pl=1 next cycle, hout=0; highest priority after reset.
REQ-017 Accepted char == PATk where k = current depth, k<3: next state S(k+1), hout=0.
REQ-018 In S3 with accepted char == PAT3: hout=1 next cycle, match_cnt increments, next state = longest proper suffix of the pattern that is also a prefix (overlap fallback).
REQ-019 Mismatch (not DELIM, not PATk): next state = longest prefix of the pattern that is a suffix of (matched chars + char_in), per KMP failure function; no hout.
REQ-020 Failure/fallback table SHALL be derived from the parameters at elaboration (localparams/constant functions), not hard-coded.
REQ-021 Latency: hout and pl asserted exactly one clk after the accepting cycle; back-to-back valid characters supported every cycle with no stall.
REQ-022 match_cnt saturates at 8'hFF; no wrap-around.
REQ-023 hout and pl SHALL never be high in the same cycle.
REQ-024 Comparisons are full 8-bit equality, subject to REQ-029.

Reset
REQ-025 reset=1 at a rising edge: state S0, hout=0, pl=0, match_cnt=0, state_dbg=0, regardless of char_valid.
REQ-026 reset mid-word discards partial match; first character after reset is evaluated from S0.
REQ-027 No asynchronous path from reset to any output.

Configuration
REQ-028 Macro STRING_MATCHER_CASE_FOLD_EN selects case-insensitive matching.
REQ-029 Defined: char_in in 8'h41..8'h5A and PATn in the same range are mapped +8'h20 before every comparison (DELIM compare unchanged); undefined: exact byte compare, no folding logic synthesized.

Verification
REQ-030 reset, then "abcd" on consecutive cycles -> hout=1 one cycle after 'd', match_cnt=1, state_dbg=0.
REQ-031 "abxabcd" -> single hout after final 'd'; state_dbg sequence 1,2,0,1,2,3,0.
REQ-032 PAT="abab", stream "ababab" -> hout after 4th and 6th chars, match_cnt=2 (overlap via fallback to S2).
REQ-033 "abc", space, "d" -> pl=1 one cycle after space, no hout, state S0 after space.
REQ-034 "ab", reset pulse, "cd" -> no hout; match_cnt=0; valid gaps inside "a_b_c_d" (char_valid low between chars) still yield one hout.
REQ-035 256 matches -> match_cnt=8'hFF held; with STRING_MATCHER_CASE_FOLD_EN, "ABcD" -> hout=1; without it, no hout.
